// File: rtl/bcd2hex.sv
// Sequential BCD-to-binary converter (reverse double dabble) with start/valid
// handshake, output range saturation and illegal-digit detection.
module bcd2hex #(
  parameter int input_size_in_nybbles = 6,
  parameter int output_width          = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [4*input_size_in_nybbles-1:0] bcd_in,
  output logic                               busy,
  output logic                               valid,
  output logic [output_width-1:0]            hex_out,
  output logic                               overflow,
  output logic                               error,
  output logic [1:0]                         fsm_state
);

  localparam int D  = input_size_in_nybbles;
  localparam int N  = 4 * D;
  localparam int W  = output_width;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    scratch;
  logic [N-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic            err_pending;

  logic [N-1:0]    shifted;
  logic [N-1:0]    corrected;
  logic            bad_digit;
  logic            high_nz;

  assign fsm_state = state;

  // A digit above 9 anywhere in the request short-circuits straight to DONE.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse-dabble step: shift right, then pull every digit >= 8 back by 3.
  always_comb begin
    shifted   = {1'b0, scratch[N-1:1]};
    corrected = shifted;
    for (int i = 0; i < D; i++) begin
      if (shifted[4*i +: 4] >= 4'd8) corrected[4*i +: 4] = shifted[4*i +: 4] - 4'd3;
    end
  end

  generate
    if (W < N) begin : g_range
      assign high_nz = |acc[N-1:W];
    end else begin : g_full
      assign high_nz = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      valid       <= 1'b0;
      hex_out     <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      scratch     <= '0;
      acc         <= '0;
      cnt         <= '0;
      err_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          busy  <= start;
          if (start) begin
            scratch     <= bcd_in;
            acc         <= '0;
            cnt         <= '0;
            err_pending <= bad_digit;
            state       <= bad_digit ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc     <= {scratch[0], acc[N-1:1]};
          scratch <= corrected;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        DONE: begin
          valid <= 1'b1;
          if (err_pending) begin
            hex_out  <= '0;
            error    <= 1'b1;
            overflow <= 1'b0;
          end else if (high_nz) begin
            hex_out  <= '1;
            error    <= 1'b0;
            overflow <= 1'b1;
          end else begin
            hex_out  <= acc[W-1:0];
            error    <= 1'b0;
            overflow <= 1'b0;
          end
          // busy stays high through the valid cycle and drops in IDLE
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2hex.sv
// Directed bench for bcd2hex: hand-computed vectors, latency/busy checks,
// back-to-back starts, ignored starts and reset abort.
module tb_bcd2hex;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] bcd_in;
  logic        busy, valid, overflow, error;
  logic [15:0] hex_out;
  logic [1:0]  fsm_state;
  logic        busy20, valid20, overflow20, error20;
  logic [19:0] hex20;
  logic [1:0]  fsm_state20;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_q[$];

  bcd2hex #(.input_size_in_nybbles(6), .output_width(16)) dut (
    .clock(clock), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .valid(valid), .hex_out(hex_out), .overflow(overflow),
    .error(error), .fsm_state(fsm_state)
  );

  bcd2hex #(.input_size_in_nybbles(6), .output_width(20)) dut20 (
    .clock(clock), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy20), .valid(valid20), .hex_out(hex20), .overflow(overflow20),
    .error(error20), .fsm_state(fsm_state20)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request and check latency, busy length and the result.
  task automatic convert(input string tag, input logic [23:0] bcd, input logic [15:0] exp_hex,
                         input logic exp_ovf, input logic exp_err, input int exp_lat);
    int lat, busy_cnt;
    logic got;
    logic [15:0] e;
    exp_q.push_back(exp_hex);
    @(negedge clock);
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = 24'h0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (valid) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    check({tag, "_valid_seen"}, got, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_hex"}, hex_out, e);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_err"}, error, exp_err);
    tick();
    check({tag, "_valid_fall"}, valid, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    if (!exp_err) check({tag, "_busy_cycles"}, busy_cnt, 26);
  endtask

  initial begin
    int nvalid, first_edge, second_edge;
    logic [15:0] cap;
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 24'h0;
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_hex", hex_out, 16'h0);
    check("rst_flags", {overflow, error}, 2'b00);
    reset = 1'b0;
    tick();

    convert("zero", 24'h000000, 16'h0000, 1'b0, 1'b0, 25);
    convert("n12345", 24'h012345, 16'h3039, 1'b0, 1'b0, 25);
    convert("n65535", 24'h065535, 16'hFFFF, 1'b0, 1'b0, 25);
    convert("n65536", 24'h065536, 16'hFFFF, 1'b1, 1'b0, 25);
    convert("n999999", 24'h999999, 16'hFFFF, 1'b1, 1'b0, 25);
    check("w20_hex", hex20, 20'hF423F);
    check("w20_ovf", overflow20, 1'b0);
    convert("errA", 24'h00A123, 16'h0000, 1'b0, 1'b1, 1);
    convert("errF", 24'h00000F, 16'h0000, 1'b0, 1'b1, 1);

    // second start while busy must be ignored
    @(negedge clock);
    start = 1'b1; bcd_in = 24'h000100;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; bcd_in = 24'h000200;
    tick();
    start = 1'b0;
    nvalid = 0;
    cap = '0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (valid) begin
        nvalid++;
        cap = hex_out;
      end
    end
    check("ign_count", nvalid, 1);
    check("ign_hex", cap, 16'h0064);

    // start held high: back-to-back conversions
    @(negedge clock);
    start = 1'b1; bcd_in = 24'h000007;
    first_edge = -1;
    second_edge = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (valid) begin
        check("hold_hex", hex_out, 16'h0007);
        if (first_edge < 0) first_edge = i;
        else begin
          second_edge = i;
          break;
        end
      end
    end
    start = 1'b0;
    check("hold_first", first_edge, 25);
    check("hold_spacing", second_edge - first_edge, 26);
    repeat (30) tick();

    // reset at edge 10 of a conversion aborts it
    @(negedge clock);
    start = 1'b1; bcd_in = 24'h012345;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_valid", valid, 1'b0);
    check("abort_hex", hex_out, 16'h0);
    check("abort_flags", {overflow, error}, 2'b00);
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    convert("n42", 24'h000042, 16'h002A, 1'b0, 1'b0, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd2hex.md
# bcd2hex

Sequential BCD-to-binary converter (reverse double dabble), the decoding counterpart of `hex2bcd`. It accepts a packed BCD number, for example from a digit-entry front end or a BCD counter, and returns the unsigned binary value after a fixed number of cycles. The block has a start/valid handshake, range checking against the output width, and detection of illegal BCD digits. It sits between BCD-domain logic and binary-domain arithmetic on the single system clock.

## Interface
- `input_size_in_nybbles`, default 6: number of BCD digits D; the `bcd_in` width is 4*D.
- `output_width`, default 16: width W of `hex_out`; 1 ≤ W ≤ 4*D.
- `clock` input 1: system clock; all logic on posedge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: request conversion of `bcd_in`; sampled only in IDLE.
- `bcd_in` input 4*D: packed BCD, digit 0 in [3:0]; captured on the accepting edge.
- `busy` output 1: conversion in progress; `start` is ignored while high.
- `valid` output 1: one-cycle pulse; `hex_out`/`overflow`/`error` are updated on the same edge.
- `hex_out` output W: converted value; holds until the next `valid`.
- `overflow` output 1: value exceeded 2^W−1; `hex_out` saturated to all ones.
- `error` output 1: at least one input digit was greater than 9; `hex_out` forced to 0.

## Operation
- State machine IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - When `start` is 1, latch `bcd_in` into the BCD scratch register, clear the 4*D-bit binary accumulator, clear the iteration counter, and set `busy`.
  - If any latched digit is greater than 9, go to DONE with an error pending. Otherwise go to SHIFT.
- **SHIFT:** each cycle performs one iteration.
  - Shift the accumulator right by 1, inserting scratch[0] at its MSB.
  - Shift the scratch register right by 1, inserting 0.
  - Then, for every scratch digit ≥ 8, subtract 3 from that digit. All digits are corrected in parallel in the same cycle.
  - The counter increments on each iteration. After iteration 4*D (counter = 4*D−1), go to DONE.
- **DONE:** one cycle, then back to IDLE; `busy` is cleared on the exit edge.
  - On error: `hex_out` = 0, `error` = 1, `overflow` = 0.
  - Otherwise, if accumulator[4*D−1:W] ≠ 0: `hex_out` = all ones, `overflow` = 1.
  - Otherwise: `hex_out` = accumulator[W−1:0], with both flags 0.
  - `valid` is driven to 1 for exactly one cycle.
- The counter width is ceil(log2(4*D)) + 1 bits; no wrap is possible within one conversion.
- Reset values: state IDLE; `busy`=0, `valid`=0, `hex_out`=0, `overflow`=0, `error`=0; scratch, accumulator and counter all 0.
- Reset mid-conversion aborts the conversion immediately. No `valid` is emitted for the aborted request.
- `start` held high continuously: a new conversion is accepted on the first IDLE edge, which is the edge after `valid`. No request is queued while busy.
- `overflow` and `error` are mutually exclusive. Error takes priority.

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
- **Legal input:**
  - `busy` is 1 after edge 0.
  - SHIFT iterations occur on edges 1 … 4*D.
  - On edge 4*D+1 (DONE), `valid`=1 with results. `busy` is still 1 during that `valid` cycle and falls at edge 4*D+2.
  - `valid` falls at edge 4*D+2.
  - Throughput: one conversion per 4*D+2 cycles.
- **Illegal digit:** DONE at edge 1; `valid`/`error` are high for the cycle after edge 1, i.e. latency 1.
- For D=6, a legal input takes 25 cycles from edge 0 to the `valid` output edge.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- `bcd_in` may change freely after edge 0.

## Test plan
- Reset, then `bcd_in`=0x000000 with `start` → after 25 edges, `valid` pulses once; `hex_out`=0x0000, `overflow`=0, `error`=0.
- `bcd_in`=0x012345 → `hex_out`=0x3039. Then 0x065535 → 0xFFFF with `overflow`=0. Check `busy` is high for exactly 26 cycles.
- `bcd_in`=0x065536 → `hex_out`=0xFFFF, `overflow`=1. Then 0x999999 → 0xFFFF, `overflow`=1. With W=20, 0x999999 → 0xF423F, `overflow`=0.
- `bcd_in`=0x00A123 → `valid` on edge 1, `error`=1, `hex_out`=0x0000. Then 0x00000F → same error response.
- Pulse `start` with 0x000100, then pulse `start` again with 0x000200 while `busy` → only one `valid`, `hex_out`=0x0064. Then hold `start` high with 0x000007 → back-to-back `valid` pulses 26 cycles apart, each with `hex_out`=0x0007.
- Assert `reset` at edge 10 of a conversion of 0x012345 → all outputs 0 after the reset edge, and no `valid`. Then a fresh conversion of 0x000042 → `hex_out`=0x002A.
